// File: rtl/c_pipeline_pkg.sv
// Shared definitions for the four-phase C-element micropipeline.
package c_pipeline_pkg;

  // Bit positions of the individual protocol-violation causes.
  localparam int ERR_WITHDRAW = 0;  // req_in dropped before it was acknowledged
  localparam int ERR_REREQ    = 1;  // req_in raised while ack_out still high
  localparam int ERR_DATA     = 2;  // data_in moved during an unacknowledged request
  localparam int ERR_NUM      = 3;

  typedef logic [ERR_NUM-1:0] err_vec_t;

  // Muller C-element: follow the inputs when they agree, otherwise hold.
  function automatic logic c_next(input logic a, input logic b, input logic z);
    return (a == b) ? a : z;
  endfunction

endpackage

// File: rtl/c_pipeline_stage.sv
// One micropipeline stage: a clocked C-element bit plus its bundled data.
module c_stage
  import c_pipeline_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_i,   // request from the left (z[i-1] or req_in)
  input  logic             b_i,   // inverted state of the right (~z[i+1] or ~ack_in)
  input  logic [WIDTH-1:0] d_i,   // data from the left
  output logic             z_o,
  output logic [WIDTH-1:0] d_o
);

  logic             z_q, z_d, upd;
  logic [WIDTH-1:0] d_q, d_d;

  // Next state; data is latched only on the 0->1 transition of z.
  always_comb begin
    z_d = c_next(a_i, b_i, z_q);
    upd = ~z_q & z_d;
    d_d = upd ? d_i : d_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
      d_q <= '0;
    end else begin
      z_q <= z_d;
      d_q <= d_d;
    end
  end

  assign z_o = z_q;
  assign d_o = d_q;

endmodule

// File: rtl/c_pipeline.sv
// Four-phase req/ack micropipeline of DEPTH clocked C-element stages,
// with an occupancy popcount and a sticky protocol-violation flag.
module c_pipeline
  import c_pipeline_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  output logic             ack_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             req_out,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  logic [DEPTH-1:0]            z;
  logic [DEPTH-1:0][WIDTH-1:0] d;

  logic             req_in_q, err_q, err_d;
  logic [WIDTH-1:0] data_in_q;
  err_vec_t         cause;
  logic [CNT_W-1:0] pop;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             a, b;
    logic [WIDTH-1:0] dp;

    if (i == 0) begin : g_head
      assign a  = req_in;
      assign dp = data_in;
    end else begin : g_body
      assign a  = z[i-1];
      assign dp = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign b = ~ack_in;
    end else begin : g_mid
      assign b = ~z[i+1];
    end

    c_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .a_i (a),
      .b_i (b),
      .d_i (dp),
      .z_o (z[i]),
      .d_o (d[i])
    );
  end

  // Occupancy: number of stages currently holding z=1.
  always_comb begin
    pop = '0;
    for (int i = 0; i < DEPTH; i++) pop = pop + CNT_W'(z[i]);
  end

  // Producer-side protocol checks against last cycle's req/data.
  always_comb begin
    cause               = '0;
    cause[ERR_WITHDRAW] = req_in_q & ~req_in & ~ack_out;
    cause[ERR_REREQ]    = ~req_in_q & req_in & ack_out;
    cause[ERR_DATA]     = req_in_q & req_in & ~ack_out & (data_in != data_in_q);
    err_d               = err_q | (|cause);
  end

  // Input history and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_in_q  <= 1'b0;
      data_in_q <= '0;
      err_q     <= 1'b0;
    end else begin
      req_in_q  <= req_in;
      data_in_q <= data_in;
      err_q     <= err_d;
    end
  end

  assign ack_out  = z[0];
  assign req_out  = z[DEPTH-1];
  assign data_out = d[DEPTH-1];
  assign count    = pop;
  assign err      = err_q;

endmodule

// File: tb/tb_c_pipeline.sv
// Directed bench for c_pipeline: DEPTH=4 main instance plus DEPTH=1/3 builds.
module tb_c_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DEPTH=4 instance
  logic       req_in = 1'b0, ack_in = 1'b0;
  logic [2:0] data_in = 3'd0;
  logic       ack_out, req_out, err;
  logic [2:0] data_out;
  logic [2:0] count;

  // DEPTH=1 instance
  logic       r1_req = 1'b0, r1_ack = 1'b0;
  logic [2:0] r1_din = 3'd0;
  logic       r1_ack_out, r1_req_out, r1_err;
  logic [2:0] r1_dout;
  logic [0:0] r1_cnt;

  // DEPTH=3 instance
  logic       r3_req = 1'b0, r3_ack = 1'b0;
  logic [2:0] r3_din = 3'd0;
  logic       r3_ack_out, r3_req_out, r3_err;
  logic [2:0] r3_dout;
  logic [1:0] r3_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  c_pipeline #(.WIDTH(3), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out), .data_in(data_in),
    .req_out(req_out), .ack_in(ack_in), .data_out(data_out), .count(count), .err(err)
  );

  c_pipeline #(.WIDTH(3), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .req_in(r1_req), .ack_out(r1_ack_out), .data_in(r1_din),
    .req_out(r1_req_out), .ack_in(r1_ack), .data_out(r1_dout), .count(r1_cnt), .err(r1_err)
  );

  c_pipeline #(.WIDTH(3), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .req_in(r3_req), .ack_out(r3_ack_out), .data_in(r3_din),
    .req_out(r3_req_out), .ack_in(r3_ack), .data_out(r3_dout), .count(r3_cnt), .err(r3_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reset everything; returns at a negedge with rst released.
  task automatic do_reset();
    req_in = 1'b0; ack_in = 1'b0; data_in = 3'd0;
    r1_req = 1'b0; r1_ack = 1'b0; r1_din = 3'd0;
    r3_req = 1'b0; r3_ack = 1'b0; r3_din = 3'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full four-phase producer transaction on the DEPTH=4 instance.
  task automatic produce(input logic [2:0] v, input string tag);
    int n;
    data_in = v;
    req_in  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack_out && n < 40);
    chk({tag, "_ack"}, 32'(ack_out), 1);
    req_in = 1'b0;
    n = 0;
    while (ack_out && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_rel"}, 32'(ack_out), 0);
  endtask

  // Four-phase consumer transaction; acks one cycle after seeing req_out.
  task automatic consume(input logic [2:0] v, input string tag);
    int n;
    n = 0;
    while (!req_out && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_req"}, 32'(req_out), 1);
    chk({tag, "_data"}, 32'(data_out), 32'(v));
    @(negedge clk);
    ack_in = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (req_out && n < 40);
    chk({tag, "_rtz"}, 32'(req_out), 0);
    ack_in = 1'b0;
  endtask

  // Leaves the DEPTH=4 pipe at z=0,1,0,1 with a third request pending.
  task automatic setup_blocked(input logic [2:0] v3);
    do_reset();
    produce(3'd5, "blk1");
    produce(3'd6, "blk2");
    data_in = v3;
    req_in  = 1'b1;
    repeat (3) @(negedge clk);
    chk("blk_err_clean", 32'(err), 0);
  endtask

  initial begin
    int  n;
    logic ok;

    // Reset state
    @(negedge clk);
    chk("rst_ack_out", 32'(ack_out), 0);
    chk("rst_req_out", 32'(req_out), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);

    // Single item, edge-accurate
    do_reset();
    data_in = 3'b101;
    req_in  = 1'b1;
    @(posedge clk); #1;
    chk("si_e0_ack", 32'(ack_out), 1);
    chk("si_e0_cnt", 32'(count), 1);
    @(posedge clk); #1;
    chk("si_e1_req", 32'(req_out), 0);
    @(posedge clk); #1;
    chk("si_e2_req", 32'(req_out), 0);
    chk("si_e2_cnt", 32'(count), 3);
    @(posedge clk); #1;
    chk("si_e3_req", 32'(req_out), 1);
    chk("si_e3_data", 32'(data_out), 5);
    chk("si_e3_cnt", 32'(count), 4);
    @(negedge clk);
    req_in = 1'b0;
    ack_in = 1'b1;
    @(posedge clk); #1;
    chk("si_e4_ack", 32'(ack_out), 0);
    chk("si_e4_cnt", 32'(count), 3);
    repeat (3) @(posedge clk);
    #1;
    chk("si_e7_req", 32'(req_out), 0);
    chk("si_e7_cnt", 32'(count), 0);
    @(negedge clk);
    ack_in = 1'b0;
    chk("si_err", 32'(err), 0);

    // Back-pressure: ack_in held low, three items offered
    do_reset();
    produce(3'd1, "bp1");
    produce(3'd2, "bp2");
    data_in = 3'd3;
    req_in  = 1'b1;
    ok = 1'b1;
    repeat (20) begin @(negedge clk); if (ack_out) ok = 1'b0; end
    chk("bp3_noack", 32'(ok), 1);
    chk("bp_count", 32'(count), 2);
    chk("bp_req_out", 32'(req_out), 1);
    chk("bp_dout", 32'(data_out), 1);
    fork
      begin
        consume(3'd1, "bpc1");
        consume(3'd2, "bpc2");
        consume(3'd3, "bpc3");
      end
      begin
        n = 0;
        while (!ack_out && n < 60) begin @(negedge clk); n++; end
        chk("bp3_late_ack", 32'(ack_out), 1);
        req_in = 1'b0;
        n = 0;
        while (ack_out && n < 40) begin @(negedge clk); n++; end
        chk("bp3_rel", 32'(ack_out), 0);
      end
    join
    chk("bp_err", 32'(err), 0);

    // Streaming 0..7
    do_reset();
    fork
      for (int i = 0; i < 8; i++) produce(3'(i), "sp");
      for (int j = 0; j < 8; j++) consume(3'(j), "sc");
    join
    repeat (2) @(negedge clk);
    chk("st_err", 32'(err), 0);
    chk("st_count", 32'(count), 0);

    // Violation: withdraw request before acknowledge
    setup_blocked(3'd0);
    req_in = 1'b0;
    @(posedge clk); #1;
    chk("vw_err", 32'(err), 1);
    repeat (5) @(negedge clk);
    chk("vw_sticky", 32'(err), 1);
    do_reset();
    chk("vw_cleared", 32'(err), 0);

    // Violation: data change during pending request
    setup_blocked(3'b000);
    data_in = 3'b111;
    @(posedge clk); #1;
    chk("vd_err", 32'(err), 1);
    repeat (5) @(negedge clk);
    chk("vd_sticky", 32'(err), 1);

    // Violation: re-request while ack_out still high
    do_reset();
    data_in = 3'd0;
    req_in  = 1'b1;
    @(negedge clk);
    req_in = 1'b0;
    @(negedge clk);
    chk("vr_ack_high", 32'(ack_out), 1);
    chk("vr_pre_err", 32'(err), 0);
    req_in = 1'b1;
    @(posedge clk); #1;
    chk("vr_err", 32'(err), 1);
    chk("vr_count", 32'(count), 3);
    repeat (4) @(negedge clk);
    chk("vr_sticky", 32'(err), 1);

    // Async reset mid-transfer with z non-zero
    chk("ar_pre_cnt", 32'(count), 4);
    #2 rst = 1'b1;
    #1;
    chk("ar_ack_out", 32'(ack_out), 0);
    chk("ar_req_out", 32'(req_out), 0);
    chk("ar_data_out", 32'(data_out), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_err", 32'(err), 0);
    req_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ar_err_after", 32'(err), 0);

    // DEPTH=1: one-edge latency, capacity one
    do_reset();
    r1_din = 3'd6;
    r1_req = 1'b1;
    chk("d1_pre_req", 32'(r1_req_out), 0);
    @(posedge clk); #1;
    chk("d1_req_out", 32'(r1_req_out), 1);
    chk("d1_ack_out", 32'(r1_ack_out), 1);
    chk("d1_dout", 32'(r1_dout), 6);
    @(negedge clk);
    r1_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("d1_full_ack", 32'(r1_ack_out), 1);
    chk("d1_cnt", 32'(r1_cnt), 1);
    r1_ack = 1'b1;
    @(posedge clk); #1;
    chk("d1_drain_req", 32'(r1_req_out), 0);
    chk("d1_drain_ack", 32'(r1_ack_out), 0);
    @(negedge clk);
    r1_ack = 1'b0;
    chk("d1_err", 32'(r1_err), 0);

    // DEPTH=3: capacity two with ack_in low
    do_reset();
    r3_din = 3'd1;
    r3_req = 1'b1;
    @(posedge clk); #1;
    chk("d3_e0_ack", 32'(r3_ack_out), 1);
    @(negedge clk);
    r3_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("d3_e2_ack", 32'(r3_ack_out), 0);
    @(negedge clk);
    r3_din = 3'd2;
    r3_req = 1'b1;
    @(posedge clk); #1;
    chk("d3_e3_ack", 32'(r3_ack_out), 0);
    @(posedge clk); #1;
    chk("d3_e4_ack", 32'(r3_ack_out), 1);
    chk("d3_e4_req_out", 32'(r3_req_out), 1);
    chk("d3_e4_dout", 32'(r3_dout), 1);
    @(negedge clk);
    r3_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("d3_stuck_ack", 32'(r3_ack_out), 1);
    chk("d3_stuck_cnt", 32'(r3_cnt), 2);
    @(negedge clk);
    r3_ack = 1'b1;
    @(posedge clk); #1;
    chk("d3_a_req_out", 32'(r3_req_out), 0);
    @(negedge clk);
    r3_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("d3_c_req_out", 32'(r3_req_out), 1);
    chk("d3_c_dout", 32'(r3_dout), 2);
    @(negedge clk);
    r3_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("d3_e_req_out", 32'(r3_req_out), 0);
    chk("d3_e_cnt", 32'(r3_cnt), 0);
    @(negedge clk);
    r3_ack = 1'b0;
    chk("d3_err", 32'(r3_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Hard stop if anything above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
